mcpu_ram_controller: RTL and testbench

Unified single-clock memory for the MCPU, shared by the data path and the instruction fetch unit. It holds RAM_SIZE words of WORD_SIZE bits. The block provides one read/write data port and one independent read-only instruction port, and both ports see the same storage. The CPU core drives the data port for load/store and the fetch stage drives the instruction port every cycle.

---
 rtl/mcpu_ram_controller.sv | 78 +++++++
 tb/tb_mcpu_ram_controller.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mcpu_ram_controller.sv
// Unified MCPU memory: one read/write data port plus one read-only fetch port.
// Define MCPU_RAM_FWD_EN for write-to-read forwarding; default is read-first.
module mcpu_ram_controller #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [WORD_SIZE-1:0]  datawr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [WORD_SIZE-1:0]  datard,
  input  logic [ADDR_WIDTH-1:0] instraddr,
  output logic [WORD_SIZE-1:0]  instrrd
);

  localparam int IW =
    (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] LP_SIZE =
    (ADDR_WIDTH+1)'(RAM_SIZE);

  logic [WORD_SIZE-1:0] mem [RAM_SIZE-1:0];

  logic [WORD_SIZE-1:0] r_datard;
  logic [WORD_SIZE-1:0] r_instrrd;

  logic                 w_d_in;
  logic                 w_i_in;
  logic                 w_wr;
  logic                 w_same;
  logic [IW-1:0]        w_d_idx;
  logic [IW-1:0]        w_i_idx;
  logic [WORD_SIZE-1:0] w_d_nxt;
  logic [WORD_SIZE-1:0] w_i_nxt;

  assign w_d_in  = ({1'b0, addr} < LP_SIZE);
  assign w_i_in  = ({1'b0, instraddr} < LP_SIZE);
  assign w_wr    = we & w_d_in;
  assign w_same  = (addr == instraddr);
  assign w_d_idx = addr[IW-1:0];
  assign w_i_idx = instraddr[IW-1:0];

  // Read data for the next edge; a disabled data read returns 0.
  always_comb begin
    w_d_nxt = '0;
    w_i_nxt = '0;
    if (re && w_d_in)
      w_d_nxt = mem[w_d_idx];
    if (w_i_in)
      w_i_nxt = mem[w_i_idx];
`ifdef MCPU_RAM_FWD_EN
    if (re && w_wr)
      w_d_nxt = datawr;
    if (w_wr && w_same)
      w_i_nxt = datawr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RAM_SIZE; k++)
        mem[k] <= '0;
      r_datard  <= '0;
      r_instrrd <= '0;
    end else begin
      if (w_wr)
        mem[w_d_idx] <= datawr;
      r_datard  <= w_d_nxt;
      r_instrrd <= w_i_nxt;
    end
  end

  assign datard  = r_datard;
  assign instrrd = r_instrrd;

endmodule

// File: tb/tb_mcpu_ram_controller.sv
// Randomized bench for mcpu_ram_controller against an array reference model.
// Define MCPU_RAM_FWD_EN here as well when building the forwarding variant.
module tb_mcpu_ram_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [7:0] datawr = '0;
  logic       re = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] datard;
  logic [7:0] instraddr = '0;
  logic [7:0] instrrd;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] model [256];
  logic [7:0] snap  [256];

  always #5 clk = ~clk;

  mcpu_ram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .datawr    (datawr),
    .re        (re),
    .addr      (addr),
    .datard    (datard),
    .instraddr (instraddr),
    .instrrd   (instrrd)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic       r,
                      input logic       w,
                      input logic [7:0] d,
                      input logic       rd,
                      input logic [7:0] a,
                      input logic [7:0] ia,
                      input string      tag);
    logic [7:0] ed;
    logic [7:0] ei;
    @(negedge clk);
    rst = r; we = w; datawr = d;
    re = rd; addr = a; instraddr = ia;
    if (r) begin
      ed = '0;
      ei = '0;
    end else begin
      ed = rd ? model[a] : 8'h00;
      ei = model[ia];
`ifdef MCPU_RAM_FWD_EN
      if (w && rd) ed = d;
      if (w && ia == a) ei = d;
`endif
    end
    @(posedge clk);
    #1;
    if (r) begin
      foreach (model[k]) model[k] = '0;
    end else if (w) begin
      model[a] = d;
    end
    chk({tag, "_d"}, {24'h0, datard}, {24'h0, ed});
    chk({tag, "_i"}, {24'h0, instrrd}, {24'h0, ei});
  endtask

  initial begin
    logic [7:0] col;
    foreach (model[k]) model[k] = 8'h5A;

    // reset wins over a same-cycle write
    step(1, 1, 8'hFF, 1, 8'h08, 8'h08, "rst_pri");
    chk("rst_mem8", {24'h0, dut.mem[8]}, 32'h0);

    for (int i = 0; i < 256; i++)
      step(0, 0, 8'h00, 1, i[7:0], i[7:0], "rst_rd");

    for (int i = 0; i < 256; i++)
      step(0, 1, 8'($urandom), 0, i[7:0],
           8'($urandom), "fill");
    for (int i = 0; i < 256; i++) begin
      snap[i] = dut.mem[i];
      chk("snap", {24'h0, snap[i]}, {24'h0, model[i]});
    end
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 8'h00, 1, i[7:0], i[7:0], "rdback");
      chk("rdback_snap", {24'h0, datard}, {24'h0, snap[i]});
    end

    step(0, 1, 8'hA5, 0, 8'h10, 8'h00, "w10");
    step(0, 1, 8'h3C, 0, 8'h20, 8'h00, "w20");
    step(0, 0, 8'h00, 1, 8'h10, 8'h20, "indep");
    chk("indep_a5", {24'h0, datard}, 32'hA5);
    chk("indep_3c", {24'h0, instrrd}, 32'h3C);

    step(0, 1, 8'h77, 0, 8'h05, 8'h00, "w05");
    step(0, 0, 8'h00, 0, 8'h05, 8'h05, "rdis");
    chk("rdis_d0", {24'h0, datard}, 32'h0);
    chk("rdis_i77", {24'h0, instrrd}, 32'h77);

`ifdef MCPU_RAM_FWD_EN
    col = 8'h22;
`else
    col = 8'h11;
`endif
    step(0, 1, 8'h11, 0, 8'h40, 8'h00, "w40");
    step(0, 1, 8'h22, 1, 8'h40, 8'h40, "coll");
    chk("coll_d", {24'h0, datard}, {24'h0, col});
    chk("coll_i", {24'h0, instrrd}, {24'h0, col});
    step(0, 0, 8'h00, 1, 8'h40, 8'h40, "coll_nx");
    chk("coll_nx_d", {24'h0, datard}, 32'h22);
    chk("coll_nx_i", {24'h0, instrrd}, 32'h22);

    for (int i = 0; i < 800; i++) begin
      logic [7:0] a;
      logic [7:0] ia;
      a  = 8'($urandom_range(0, 15));
      ia = ($urandom_range(0, 1) == 1) ?
           a : 8'($urandom_range(0, 15));
      step($urandom_range(0, 99) == 0,
           1'($urandom), 8'($urandom),
           1'($urandom), a, ia, "rnd");
    end

    for (int i = 0; i < 256; i++)
      chk("final_mem", {24'h0, dut.mem[i]},
          {24'h0, model[i]});

    step(1, 1, 8'hEE, 1, 8'h03, 8'h03, "rst_end");
    chk("rst_end_mem3", {24'h0, dut.mem[3]}, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
